// File: rtl/ones_stream_gen_pkg.sv
// Shared definitions for the thermometer-frame generator: FSM states and
// default frame geometry.
package ones_stream_gen_pkg;

  localparam int DEF_WIDTH = 15;
  localparam int DEF_CW    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/ones_stream_gen_therm_encoder.sv
// Combinational thermometer encoder: bit i of word is set iff i < count.
// Counts above WIDTH saturate to an all-ones word and raise clamp.
module therm_encoder
  import ones_stream_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] word,
  output logic             clamp
);

  localparam logic [CW-1:0] WMAX = CW'(WIDTH);

  // A count larger than WIDTH already sets every bit, so clamping is implicit.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign word[g] = (count > CW'(g));
  end

  assign clamp = (count > WMAX);

endmodule

// File: rtl/ones_stream_gen.sv
// Serial thermometer-frame generator: accepts a ones count and emits a
// WIDTH-bit frame with exactly min(count, WIDTH) leading ones, LSB first.
module ones_stream_gen
  import ones_stream_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             sat
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_r;
  logic [CW-1:0]    idx_r;
  logic [CW-1:0]    idx_nxt_s;
  logic [WIDTH-1:0] enc_word_s;
  logic             enc_clamp_s;

  therm_encoder #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_enc (
    .count (in_count),
    .word  (enc_word_s),
    .clamp (enc_clamp_s)
  );

  assign idx_nxt_s = idx_r + {{(CW-1){1'b0}}, 1'b1};

  // Frame FSM; every output is a register so the serial bit is picked from
  // the stored word one cycle ahead of when it is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= {CW{1'b0}};
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_last   <= 1'b0;
      word_out   <= {WIDTH{1'b0}};
      word_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r    <= SEND;
            idx_r      <= {CW{1'b0}};
            in_ready   <= 1'b0;
            out_valid  <= 1'b1;
            out_bit    <= enc_word_s[0];
            out_last   <= (LAST_IDX == {CW{1'b0}});
            word_out   <= enc_word_s;
            word_valid <= 1'b1;
            sat        <= enc_clamp_s;
          end else begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state_r   <= IDLE;
              idx_r     <= {CW{1'b0}};
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_bit   <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              idx_r    <= idx_nxt_s;
              out_bit  <= word_out[idx_nxt_s];
              out_last <= (idx_nxt_s == LAST_IDX);
            end
          end else begin
            // Backpressure: hold index and presented bit.
            idx_r    <= idx_r;
            out_bit  <= out_bit;
            out_last <= out_last;
          end
        end
        default: begin
          state_r   <= IDLE;
          idx_r     <= {CW{1'b0}};
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_bit   <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ones_stream_gen.md
ONES_STREAM_GEN -- requirements
Module: ones_stream_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 15, the frame length in bits.
REQ-002 The block SHALL have parameter CW, default 4, the count width; CW SHALL satisfy 2**CW > WIDTH.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  in_count is offered.
REQ-006 Port in_ready  output  1  block can accept a count.
REQ-007 Port in_count  input  CW  requested number of ones in the frame.
REQ-008 Port out_valid  output  1  out_bit is valid.
REQ-009 Port out_ready  input  1  sink accepts out_bit.
REQ-010 Port out_bit  output  1  current serial frame bit.
REQ-011 Port out_last  output  1  current bit is the final frame bit (index WIDTH-1).
REQ-012 Port word_out  output  WIDTH  parallel thermometer word of the accepted count.
REQ-013 Port word_valid  output  1  one-cycle pulse: word_out just updated.
REQ-014 Port sat  output  1  accepted count exceeded WIDTH and was clamped.

Function
REQ-015 The block SHALL be the inverse of the team's ones counter: every emitted frame SHALL contain exactly N ones, N = min(in_count, WIDTH).
REQ-016 Frame bit order SHALL be thermometer: bits at index 0..N-1 are 1, index N..WIDTH-1 are 0; index 0 is sent first.
REQ-017 FSM states SHALL be IDLE and SEND only.
REQ-018 IDLE: in_ready=1, out_valid=0; on in_valid=1 the count is accepted in that cycle and the FSM SHALL enter SEND with bit index 0.
REQ-019 At acceptance the block SHALL register word_out (bit i = 1 iff i < N), assert word_valid for exactly the next cycle, and set sat=1 iff in_count > WIDTH, else 0.
REQ-020 word_out and sat SHALL hold their value until the next acceptance.
REQ-021 SEND: in_ready=0, out_valid=1, out_bit = (index < N), out_last = (index == WIDTH-1).
REQ-022 Index SHALL advance by 1 only in cycles where out_valid and out_ready are both 1; otherwise out_bit, out_last and index SHALL hold (no bit lost or repeated under backpressure).
REQ-023 A transfer with out_last=1 SHALL return the FSM to IDLE; in_ready SHALL be 1 in the following cycle (no same-cycle back-to-back acceptance).
REQ-024 Latency: count accepted in cycle T → first out_valid in cycle T+1; with out_ready held 1 the last bit is in cycle T+WIDTH.
REQ-025 in_valid during SEND SHALL be ignored (in_ready=0); the offered count is not consumed.
REQ-026 N=0 SHALL still emit a full WIDTH-bit all-zero frame; N=WIDTH an all-ones frame.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, index 0, in_ready=1, out_valid=0, out_bit=0, out_last=0, word_out=0, word_valid=0, sat=0.
REQ-028 Reset during SEND SHALL abort the frame immediately with no further out_valid; the aborted count is not replayed.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, SEND) and the default WIDTH/CW constants.
REQ-031 One combinational sub-module therm_encoder (count in, WIDTH-bit thermometer word out, clamping above WIDTH) SHALL generate word_out; the serial bit SHALL be selected from the registered word by index.

Verification
REQ-032 in_count=5, out_ready=1 → cycles T+1..T+15 out_bit = 1,1,1,1,1,0×10; out_last only at T+15; word_out=15'h001F; word_valid at T+1.
REQ-033 in_count=0 then in_count=15 → frame of 15 zeros, then 15 ones; word_out 15'h0000 then 15'h7FFF; sat=0 both.
REQ-034 WIDTH=10, CW=4, in_count=13 → 10 ones emitted, word_out=10'h3FF, sat=1.
REQ-035 in_count=7, out_ready toggling 1,0,0,1,… → bit sequence identical to REQ-032-style reference (seven 1s, eight 0s), held stable while out_ready=0.
REQ-036 rst asserted at bit index 6 of a count-9 frame → next cycle out_valid=0, in_ready=1, word_out=0; new count 3 then produces a clean 3-ones frame.
REQ-037 Every frame across random counts fed to the team's ones counter SHALL return min(in_count, WIDTH).
